icache_loader: RTL and testbench

ICACHE_LOADER -- requirements
Module: icache_loader

---
 rtl/icache_loader_if.sv | 30 +++
 rtl/icache_loader.sv | 139 +++++++++++++
 tb/tb_icache_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_loader_if.sv
// Host byte stream, load control and tile icache write bus of the icache loader.
interface icache_loader_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned HOST_W  = 8
);
    logic               load_start;
    logic [ADDR_W:0]    load_len;
    logic               in_valid;
    logic [HOST_W-1:0]  in_data;
    logic               in_ready;
    logic               icache_write;
    logic [ADDR_W-1:0]  icache_addr;
    logic [INSTR_W-1:0] icache_data;
    logic               run;
    logic               busy;
    logic               len_err;

    // Host side: requests loads and streams bytes.
    modport master (
        output load_start, load_len, in_valid, in_data,
        input  in_ready, icache_write, icache_addr, icache_data, run, busy, len_err
    );

    // Loader side.
    modport slave (
        input  load_start, load_len, in_valid, in_data,
        output in_ready, icache_write, icache_addr, icache_data, run, busy, len_err
    );
endinterface

// File: rtl/icache_loader.sv
// Assembles a little-endian host byte stream into instructions and writes them
// into a tile icache, then raises run once the whole program is loaded.
module icache_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned HOST_W  = 8
) (
    input logic          clk,
    input logic          nrst,
    icache_loader_if.slave bus
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned BEATS  = INSTR_W / HOST_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ADDR_W:0]      r_addr;      // one extra bit so a DEPTH-long load never wraps
    logic [ADDR_W:0]      r_len;
    logic [BEAT_W-1:0]    r_beat;
    logic [INSTR_W-1:0]   r_word;
    logic                 r_len_err;
    logic                 r_in_ready;
    logic                 r_busy;
    logic                 r_run;
    logic                 r_wr;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [INSTR_W-1:0]   r_wr_data;

    logic                 w_accept;
    logic                 w_last_beat;
    logic                 w_last_instr;
    logic                 w_start_cmd;
    logic                 w_len_over;
    logic                 w_len_zero;
    logic                 w_run_next;
    logic [INSTR_W-1:0]   w_word;

    // r_in_ready mirrors state == LOAD, so it doubles as the acceptance qualifier.
    assign w_accept     = bus.in_valid && r_in_ready;
    assign w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
    assign w_last_instr = (r_addr == (r_len - 1'b1));
    assign w_start_cmd  = bus.load_start && (r_state != StLoad);
    assign w_len_over   = (bus.load_len > (ADDR_W + 1)'(DEPTH));
    assign w_len_zero   = (bus.load_len == '0);
    // run lags DONE by one cycle and drops as soon as a new load is requested.
    assign w_run_next   = (r_state == StDone) && !bus.load_start;

    // Completed word: stored beats plus the byte arriving now in the top slice.
    always_comb begin
        w_word = r_word;
        w_word[(BEATS-1)*HOST_W +: HOST_W] = bus.in_data;
    end

    // Next-state logic; DONE handles a new request exactly like IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (bus.load_start) begin
                    if (w_len_over) begin
                        w_state_next = StIdle;
                    end else if (w_len_zero) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StLoad;
                    end
                end
            end
            StLoad: begin
                if (w_accept && w_last_beat && w_last_instr) begin
                    w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters, word assembly and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_word     <= '0;
            r_len_err  <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_run      <= 1'b0;
            r_wr       <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr <= 1'b0;
            if (w_start_cmd) begin
                r_len_err <= w_len_over;
                if (!w_len_over) begin
                    r_addr <= '0;
                    r_beat <= '0;
                    r_len  <= bus.load_len;
                end
            end
            if (w_accept) begin
                r_word[r_beat*HOST_W +: HOST_W] <= bus.in_data;
                if (w_last_beat) begin
                    r_beat    <= '0;
                    r_addr    <= r_addr + 1'b1;
                    r_wr      <= 1'b1;
                    r_wr_addr <= r_addr[ADDR_W-1:0];
                    r_wr_data <= w_word;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            r_in_ready <= (w_state_next == StLoad);
            r_busy     <= (w_state_next == StLoad);
            r_run      <= w_run_next;
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.busy         = r_busy;
    assign bus.run          = r_run;
    assign bus.len_err      = r_len_err;
    assign bus.icache_write = r_wr;
    assign bus.icache_addr  = r_wr_addr;
    assign bus.icache_data  = r_wr_data;
endmodule

// File: tb/tb_icache_loader.sv
// Self-checking bench for icache_loader: start-command vector table, directed
// multi-cycle sequences and randomized loads against a queue-based reference.
module tb_icache_loader;
    logic clk = 1'b0;
    logic nrst = 1'b1;

    icache_loader_if #(.ADDR_W(8), .INSTR_W(16), .HOST_W(8)) bus ();

    icache_loader #(.ADDR_W(8), .INSTR_W(16), .HOST_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int len;
        bit err;
        bit busy;
        bit run;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  exp_q[$];
    int   wr_count = 0;
    int   last_addr = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every icache write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.icache_write) begin
            wr_t e;
            wr_count++;
            last_addr = int'(bus.icache_addr);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.icache_addr, bus.icache_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(bus.icache_addr), int'(e.addr));
                chk("wr_data", int'(bus.icache_data), int'(e.data));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        exp_q.delete();
    endtask

    task automatic start(input int len);
        @(negedge clk);
        bus.load_start = 1'b1;
        bus.load_len   = 9'(len);
    endtask

    // Reference: instruction i is bytes 2i (low) and 2i+1 (high), written to address i.
    task automatic run_load(input int len, input int gap_pct, input int inject);
        logic [7:0] bq[$];
        int idx = 0;
        int cyc = 0;
        int w = 0;
        int wc0;
        bit injected = 1'b0;
        for (int i = 0; i < 2 * len; i++) bq.push_back(8'($urandom));
        for (int i = 0; i < len; i++) exp_q.push_back({8'(i), bq[2*i+1], bq[2*i]});
        wc0 = wr_count;
        start(len);
        @(negedge clk);
        bus.load_start = 1'b0;
        chk("run_drop_on_start", int'(bus.run), 0);
        chk("len_err_clear", int'(bus.len_err), 0);
        while (idx < 2 * len && cyc < 4000) begin
            if (inject >= 0 && !injected && idx == inject) begin
                bus.load_start = 1'b1;
                bus.load_len   = 9'd3;
                injected       = 1'b1;
            end else begin
                bus.load_start = 1'b0;
            end
            if (bus.in_ready && ($urandom_range(99) >= gap_pct)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bq[idx];
                idx++;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid   = 1'b0;
        bus.load_start = 1'b0;
        chk("bytes_accepted", idx, 2 * len);
        while (!bus.run && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("run_after_load", int'(bus.run), 1);
        chk("busy_after_load", int'(bus.busy), 0);
        chk("writes_outstanding", exp_q.size(), 0);
        chk("write_count", wr_count - wc0, len);
    endtask

    vec_t vecs[6];

    initial begin
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;

        vecs[0] = '{0,   1'b0, 1'b0, 1'b1};
        vecs[1] = '{257, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{511, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{256, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1,   1'b0, 1'b1, 1'b0};
        vecs[5] = '{3,   1'b0, 1'b1, 1'b0};

        // Reset state
        #2 nrst = 1'b0;
        #2;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_run", int'(bus.run), 0);
        chk("rst_write", int'(bus.icache_write), 0);
        chk("rst_len_err", int'(bus.len_err), 0);
        #3 nrst = 1'b1;

        // Start-command vectors: status two cycles after load_start.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start(vecs[i].len);
            @(negedge clk);
            bus.load_start = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_len_err", i), int'(bus.len_err), int'(vecs[i].err));
            chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), int'(vecs[i].busy));
            chk($sformatf("vec%0d_run", i), int'(bus.run), int'(vecs[i].run));
        end

        // Two instructions, back-to-back bytes.
        do_reset();
        exp_q.push_back({8'd0, 16'h1234});
        exp_q.push_back({8'd1, 16'h5678});
        start(2);
        @(negedge clk); bus.load_start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h34;
        @(negedge clk); bus.in_data = 8'h12;
        chk("b2b_no_write_early", int'(bus.icache_write), 0);
        @(negedge clk); bus.in_data = 8'h78;
        chk("b2b_wr0", int'(bus.icache_write), 1);
        chk("b2b_wr0_addr", int'(bus.icache_addr), 0);
        chk("b2b_wr0_data", int'(bus.icache_data), 32'h1234);
        @(negedge clk); bus.in_data = 8'h56;
        chk("b2b_gap", int'(bus.icache_write), 0);
        @(negedge clk); bus.in_valid = 1'b0;
        chk("b2b_wr1", int'(bus.icache_write), 1);
        chk("b2b_wr1_addr", int'(bus.icache_addr), 1);
        chk("b2b_wr1_data", int'(bus.icache_data), 32'h5678);
        chk("b2b_ready_low", int'(bus.in_ready), 0);
        chk("b2b_run_not_yet", int'(bus.run), 0);
        @(negedge clk);
        chk("b2b_run", int'(bus.run), 1);
        chk("b2b_single_strobe", int'(bus.icache_write), 0);

        // One instruction with a three-cycle stall between beats.
        exp_q.push_back({8'd0, 16'hABCD});
        start(1);
        @(negedge clk); bus.load_start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hCD;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hEE;
            chk("stall_no_write", int'(bus.icache_write), 0);
        end
        @(negedge clk); bus.in_valid = 1'b1; bus.in_data = 8'hAB;
        chk("stall_no_write_last", int'(bus.icache_write), 0);
        @(negedge clk); bus.in_valid = 1'b0;
        chk("stall_wr", int'(bus.icache_write), 1);
        chk("stall_wr_addr", int'(bus.icache_addr), 0);
        chk("stall_wr_data", int'(bus.icache_data), 32'hABCD);

        // Zero-length load from DONE: no writes, never ready, run two cycles later.
        start(0);
        bus.in_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.load_start = 1'b0;
            chk("zero_in_ready", int'(bus.in_ready), 0);
            chk("zero_no_write", int'(bus.icache_write), 0);
            if (c == 1) chk("zero_run_drop", int'(bus.run), 0);
            if (c == 2) chk("zero_run", int'(bus.run), 1);
        end
        bus.in_valid = 1'b0;

        // Oversized length, then a full-depth load.
        do_reset();
        start(257);
        @(negedge clk); bus.load_start = 1'b0;
        chk("over_len_err", int'(bus.len_err), 1);
        chk("over_busy", int'(bus.busy), 0);
        chk("over_run", int'(bus.run), 0);
        run_load(256, 0, -1);
        chk("full_last_addr", last_addr, 255);

        // Reset mid-load abandons the partial word.
        start(1);
        @(negedge clk); bus.load_start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h99;
        @(negedge clk); bus.in_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_in_ready", int'(bus.in_ready), 0);
        chk("arst_run", int'(bus.run), 0);
        chk("arst_write", int'(bus.icache_write), 0);
        chk("arst_addr", int'(bus.icache_addr), 0);
        chk("arst_data", int'(bus.icache_data), 0);
        @(negedge clk); nrst = 1'b1;
        exp_q.push_back({8'd0, 16'h2211});
        start(1);
        @(negedge clk); bus.load_start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h11;
        @(negedge clk); bus.in_data = 8'h22;
        @(negedge clk); bus.in_valid = 1'b0;
        @(negedge clk);
        chk("arst_reload_writes", exp_q.size(), 0);

        // load_start during LOAD must not disturb the running load.
        run_load(5, 20, 4);

        // Randomized loads with random stalls.
        for (int r = 0; r < 20; r++) begin
            run_load(int'($urandom_range(1, 8)), 30, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end
endmodule
